rf_debug_port: RTL and testbench

RF_DEBUG_PORT -- requirements
Module: rf_debug_port

---
 rtl/rf_debug_port.sv | 129 ++++++++++++
 tb/tb_rf_debug_port.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_debug_port.sv
// Debug access port that halts the core and reads, writes or dumps the register file
// through its single read/write port, returning one response per register touched.
module rf_debug_port #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [4:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_addr,
  output logic            rsp_last,
  output logic            rsp_err,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic [4:0]      rf_rs1,
  input  logic [XLEN-1:0] rf_rd1,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until that edge, ready may change freely.
  typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_t;

  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DUMP   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  localparam logic [4:0] LAST_ADDR = 5'(NREGS - 1);

  state_t          state;
  logic [1:0]      op_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wr_live;

  // Writes to x0 are acknowledged but never reach the register file.
  assign wr_live   = (op_q == OP_WRITE) && (addr_q != 5'd0);
  assign cmd_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      halt_req  <= 1'b0;
      rf_we     <= 1'b0;
      rf_rs1    <= '0;
      rf_rd     <= '0;
      rf_wd     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            wdata_q <= cmd_wdata;
            if (cmd_op == OP_ILLEGAL) begin
              addr_q    <= cmd_addr;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_addr  <= cmd_addr;
              rsp_last  <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              addr_q   <= (cmd_op == OP_DUMP) ? 5'd0 : cmd_addr;
              halt_req <= 1'b1;
              state    <= HALT;
            end
          end
        end
        HALT: begin
          if (halt_ack) begin
            rf_rs1 <= addr_q;
            rf_we  <= wr_live;
            if (op_q == OP_WRITE) begin
              rf_rd <= addr_q;
              rf_wd <= wdata_q;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          rf_we     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_addr  <= addr_q;
          rsp_err   <= 1'b0;
          rsp_last  <= (op_q != OP_DUMP) || (addr_q == LAST_ADDR);
          if (op_q == OP_WRITE)
            rsp_data <= (addr_q == 5'd0) ? '0 : wdata_q;
          else
            rsp_data <= rf_rd1;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              halt_req <= 1'b0;
              state    <= IDLE;
            end else begin
              // Next dump register: the core is still halted, so go straight back to ACCESS.
              addr_q <= addr_q + 5'd1;
              rf_rs1 <= addr_q + 5'd1;
              state  <= ACCESS;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_debug_port.sv
// Directed bench for rf_debug_port: table of single commands plus hand-written
// dump, delayed-acknowledge and reset-mid-dump sequences against a register-file model.
module tb_rf_debug_port;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [4:0]      cmd_addr;
  logic [XLEN-1:0] cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_addr;
  logic            rsp_last;
  logic            rsp_err;
  logic            halt_req;
  logic            halt_ack;
  logic [4:0]      rf_rs1;
  logic [XLEN-1:0] rf_rd1;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [1:0]      dbg_state;

  rf_debug_port #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_rs1(rf_rs1), .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-file model and write/halt monitors
  logic [XLEN-1:0] rf [32];
  logic [1:0]      load_sel;
  int              we_count;
  int              halt_cycles;
  logic [4:0]      last_we_rd;
  logic [XLEN-1:0] last_we_wd;

  assign rf_rd1 = rf[rf_rs1];

  always @(posedge clk) begin
    if (load_sel != 2'd0) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= (load_sel == 2'd1 && i == 7) ? 32'h0000_0123 : 32'(i * 4);
    end else if (rf_we) begin
      rf[rf_rd] <= rf_wd;
    end
    if (rf_we) begin
      we_count   <= we_count + 1;
      last_we_rd <= rf_rd;
      last_we_wd <= rf_wd;
    end
    if (halt_req) halt_cycles <= halt_cycles + 1;
  end

  // scoreboard
  int n_cmp;
  int n_fail;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [XLEN-1:0] wd);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_seen", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    check("rsp_timeout", 64'(rsp_valid), 64'(1));
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [4:0]      addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] exp_data;
    logic [4:0]      exp_addr;
    logic            exp_last;
    logic            exp_err;
    int              exp_we;
    int              exp_lat;
    int              exp_halt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int we0;
    int h0;
    int bad;
    int got;
    logic found;
    logic [XLEN-1:0] e;

    n_cmp = 0;
    n_fail = 0;
    we_count = 0;
    halt_cycles = 0;
    last_we_rd = '0;
    last_we_wd = '0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    halt_ack = 1'b1;
    load_sel = 2'd1;

    //                op     addr   wdata         exp_data      eaddr last err we lat halt
    vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 5'd5,  1'b1, 1'b0, 1, 3, 3};
    vecs[1] = '{2'b00, 5'd7,  32'h0,        32'h00000123, 5'd7,  1'b1, 1'b0, 0, 3, 3};
    vecs[2] = '{2'b01, 5'd0,  32'd999,      32'h0,        5'd0,  1'b1, 1'b0, 0, 3, 3};
    vecs[3] = '{2'b11, 5'd4,  32'h77,       32'h0,        5'd4,  1'b1, 1'b1, 0, 1, 0};
    vecs[4] = '{2'b00, 5'd5,  32'h0,        32'hDEADBEEF, 5'd5,  1'b1, 1'b0, 0, 3, 3};
    vecs[5] = '{2'b01, 5'd31, 32'hA5A50F0F, 32'hA5A50F0F, 5'd31, 1'b1, 1'b0, 1, 3, 3};
    vecs[6] = '{2'b00, 5'd31, 32'h0,        32'hA5A50F0F, 5'd31, 1'b1, 1'b0, 0, 3, 3};
    vecs[7] = '{2'b00, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b0, 0, 3, 3};

    repeat (3) @(negedge clk);
    load_sel = 2'd0;
    check("rst_ctl", 64'({halt_req, rf_we, rsp_valid, rsp_last, rsp_err}), 64'(0));
    check("rst_data", 64'({rsp_data, rf_wd}), 64'(0));
    check("rst_addr", 64'({rsp_addr, rf_rs1, rf_rd}), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    rst_n = 1'b1;

    // single-command table
    for (int v = 0; v < 8; v++) begin
      we0 = we_count;
      h0  = halt_cycles;
      send_cmd(vecs[v].op, vecs[v].addr, vecs[v].wdata);
      wait_rsp(lat);
      check($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_data", v), 64'(rsp_data), 64'(vecs[v].exp_data));
      check($sformatf("v%0d_addr", v), 64'(rsp_addr), 64'(vecs[v].exp_addr));
      check($sformatf("v%0d_last", v), 64'(rsp_last), 64'(vecs[v].exp_last));
      check($sformatf("v%0d_err", v), 64'(rsp_err), 64'(vecs[v].exp_err));
      @(negedge clk);
      check($sformatf("v%0d_halt_drop", v), 64'(halt_req), 64'(0));
      check($sformatf("v%0d_rsp_done", v), 64'(rsp_valid), 64'(0));
      check($sformatf("v%0d_cmd_ready", v), 64'(cmd_ready), 64'(1));
      check($sformatf("v%0d_we_pulses", v), 64'(we_count - we0), 64'(vecs[v].exp_we));
      check($sformatf("v%0d_halt_cycles", v), 64'(halt_cycles - h0), 64'(vecs[v].exp_halt));
      if (vecs[v].exp_we == 1) begin
        check($sformatf("v%0d_we_rd", v), 64'(last_we_rd), 64'(vecs[v].addr));
        check($sformatf("v%0d_we_wd", v), 64'(last_we_wd), 64'(vecs[v].wdata));
      end
    end

    // full dump with rsp_ready toggling; cmd_addr must be ignored
    load_sel = 2'd2;
    @(posedge clk);
    #1;
    load_sel = 2'd0;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    we0 = we_count;
    send_cmd(2'b10, 5'd9, 32'h0);
    got = 0;
    for (int cyc = 0; cyc < 400 && got < 32; cyc++) begin
      @(negedge clk);
      rsp_ready = (cyc % 2 == 0);
      if (rsp_valid && rsp_ready) begin
        e = exp_q.pop_front();
        check($sformatf("dump%0d_data", got), 64'(rsp_data), 64'(e));
        check($sformatf("dump%0d_addr", got), 64'(rsp_addr), 64'(got));
        check($sformatf("dump%0d_last", got), 64'(rsp_last), 64'(got == 31));
        check($sformatf("dump%0d_halt", got), 64'(halt_req), 64'(1));
        got++;
      end
    end
    rsp_ready = 1'b1;
    check("dump_count", 64'(got), 64'(32));
    @(negedge clk);
    check("dump_halt_drop", 64'(halt_req), 64'(0));
    check("dump_rsp_done", 64'(rsp_valid), 64'(0));
    check("dump_no_we", 64'(we_count - we0), 64'(0));

    // delayed halt acknowledge on a write
    halt_ack = 1'b0;
    we0 = we_count;
    send_cmd(2'b01, 5'd3, 32'h000055AA);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || rf_we || !halt_req) bad++;
    end
    check("ack_wait_quiet", 64'(bad), 64'(0));
    halt_ack = 1'b1;
    wait_rsp(lat);
    check("ack_lat", 64'(lat), 64'(2));
    check("ack_data", 64'(rsp_data), 64'(32'h000055AA));
    check("ack_last", 64'(rsp_last), 64'(1));
    @(negedge clk);
    check("ack_we_pulses", 64'(we_count - we0), 64'(1));
    check("ack_we_rd", 64'(last_we_rd), 64'(3));
    check("ack_halt_drop", 64'(halt_req), 64'(0));

    // reset pulsed during a dump at address 12
    load_sel = 2'd2;
    @(posedge clk);
    #1;
    load_sel = 2'd0;
    send_cmd(2'b10, 5'd0, 32'h0);
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp_addr == 5'd12) found = 1'b1;
    end
    check("rst_dump_reached12", 64'(found), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 64'({halt_req, rf_we, rsp_valid, rsp_last, rsp_err}), 64'(0));
    check("midrst_data", 64'({rsp_data, rf_wd}), 64'(0));
    check("midrst_addr", 64'({rsp_addr, rf_rs1, rf_rd}), 64'(0));
    we0 = we_count;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || halt_req || rf_we) bad++;
    end
    check("midrst_quiet", 64'(bad), 64'(0));
    rst_n = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_addr = 5'd7;
    cmd_wdata = '0;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    check("post_rst_lat", 64'(lat), 64'(3));
    check("post_rst_data", 64'(rsp_data), 64'(28));
    check("post_rst_addr", 64'(rsp_addr), 64'(7));
    check("post_rst_last", 64'(rsp_last), 64'(1));
    @(negedge clk);
    check("post_rst_no_we", 64'(we_count - we0), 64'(0));
    check("post_rst_halt_drop", 64'(halt_req), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
